// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline registers: reset/exception PCs
// and bit offsets of the fields packed into the opaque payload.
package pipe_stage_reg_pkg;

    localparam logic [31:0] PC_INIT_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

    // Payload layout (LSB offsets) shared by every stage-boundary wrapper
    localparam int OFF_A2         = 0;   // 5 bits
    localparam int OFF_A3         = 5;   // 5 bits
    localparam int OFF_RD         = 10;  // 5 bits
    localparam int OFF_RD2        = 15;  // 32 bits
    localparam int OFF_ALUOUT     = 47;  // 32 bits
    localparam int OFF_WHICHTOREG = 79;  // 3 bits
    localparam int OFF_REGDST     = 82;  // 2 bits
    localparam int OFF_DM_TYPE    = 84;  // 3 bits
    localparam int OFF_EXCCODE    = 87;  // 5 bits
    localparam int OFF_MFC0       = 92;
    localparam int OFF_MTC0       = 93;
    localparam int OFF_ERET       = 94;
    localparam int OFF_SYSCALL    = 95;
    localparam int PAYLOAD_USED_W = 96;

endpackage

// File: rtl/pipe_stage_reg_tnew_dec.sv
// Saturating decrement of a Tnew value; zero stays zero.
module tnew_dec #(
    parameter int TNEW_W = 2
) (
    input  logic [TNEW_W-1:0] tnew_i,
    output logic [TNEW_W-1:0] tnew_o
);

    always_comb begin
        tnew_o = '0;
        if (tnew_i != '0) tnew_o = tnew_i - TNEW_W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall, bubble insertion (keeping PC/BD
// for precise EPC), exception flush and a bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          PAYLOAD_W = 128,
    parameter int          PC_W      = 32,
    parameter int          TNEW_W    = 2,
    parameter logic [31:0] PC_INIT   = PC_INIT_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter bit          DEC_TNEW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 in_bd,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [PC_W-1:0]      out_pc,
    output logic                 out_bd,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          bubble_cnt
);

    logic                 valid_q, valid_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 bd_q, bd_d;
    logic [TNEW_W-1:0]    tnew_q, tnew_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [31:0]          bubble_cnt_q, bubble_cnt_d;
    logic [TNEW_W-1:0]    tnew_dec_w, tnew_load;

    tnew_dec #(.TNEW_W(TNEW_W)) u_tnew_dec (
        .tnew_i (in_tnew),
        .tnew_o (tnew_dec_w)
    );

    generate
        if (DEC_TNEW) begin : g_dec
            assign tnew_load = tnew_dec_w;
        end else begin : g_pass
            assign tnew_load = in_tnew;
        end
    endgenerate

    // Priority below reset: req > stall > flush > load
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        bd_d         = bd_q;
        tnew_d       = tnew_q;
        payload_d    = payload_q;
        bubble_cnt_d = bubble_cnt_q;
        if (req) begin
            valid_d   = 1'b0;
            pc_d      = PC_W'(EXC_ENTRY);
            bd_d      = 1'b0;
            tnew_d    = '0;
            payload_d = '0;
        end else if (stall) begin
            // hold everything, including Tnew
        end else if (flush) begin
            valid_d      = 1'b0;
            pc_d         = in_pc;
            bd_d         = in_bd;
            tnew_d       = '0;
            payload_d    = '0;
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            valid_d   = in_valid;
            pc_d      = in_pc;
            bd_d      = in_bd;
            tnew_d    = tnew_load;
            payload_d = in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= PC_W'(PC_INIT);
            bd_q         <= 1'b0;
            tnew_q       <= '0;
            payload_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            bd_q         <= bd_d;
            tnew_q       <= tnew_d;
            payload_q    <= payload_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_bd      = bd_q;
    assign out_tnew    = tnew_q;
    assign out_payload = payload_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the hand-written D/E, E/M and M/W registers.
- Carries an opaque control/data payload plus the fields that need special handling: PC, delay-slot flag, valid bit and Tnew.
- Adds stall (hold) and bubble-insert, with PC/BD preservation for precise EPC, on top of reset and exception flush.
- Instantiated once per stage boundary; the hazard unit drives stall/flush and CP0 drives req.

Parameters:
- PAYLOAD_W, 128, width of the opaque payload (A2/A3/rd, RD2, ALUout, control, ExcCode, etc., concatenated by the instantiator).
- PC_W, 32, PC width.
- TNEW_W, 2, Tnew width.
- PC_INIT, 32'h0000_3000, PC value loaded on reset.
- EXC_ENTRY, 32'h0000_4180, PC value loaded on exception request.
- DEC_TNEW, 1, 1 = saturating-decrement Tnew on load; 0 = pass Tnew through unchanged.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt request from CP0; flushes the stage.
- stall  in  1  hold current contents (stage is frozen).
- flush  in  1  insert a bubble (stage is killed, but PC and BD are kept).
- in_valid  in  1  upstream instruction valid.
- in_pc  in  PC_W  upstream PC.
- in_bd  in  1  upstream branch-delay-slot flag.
- in_tnew  in  TNEW_W  upstream Tnew.
- in_payload  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  registered valid.
- out_pc  out  PC_W  registered PC.
- out_bd  out  1  registered BD flag.
- out_tnew  out  TNEW_W  registered Tnew.
- out_payload  out  PAYLOAD_W  registered payload.
- bubble_cnt  out  32  count of bubbles inserted by flush (debug/perf).

Behaviour:
- All outputs are registers updated on posedge clk; output latency is 1 cycle from the inputs.
- Per-cycle priority: reset > req > stall > flush > normal load.
- reset:
  - out_valid=0, out_pc=PC_INIT, out_bd=0, out_tnew=0, out_payload=0, bubble_cnt=0.
- req (reset low):
  - out_valid=0, out_pc=EXC_ENTRY, out_bd=0, out_tnew=0, out_payload=0.
  - bubble_cnt unchanged.
  - req overrides stall: an exception always flushes, even if the stage is stalled.
- stall (reset and req low):
  - Every output holds its value, and Tnew does NOT decrement.
  - flush asserted in the same cycle is ignored (stall wins); bubble_cnt unchanged.
- flush (reset, req, stall low):
  - out_valid=0, out_tnew=0, out_payload=0 (write-enables inside the payload are therefore 0).
  - out_pc=in_pc and out_bd=in_bd, so a bubble still reports the PC/BD of the stalled instruction behind it for EPC.
  - bubble_cnt increments by 1 and wraps 2^32-1 -> 0.
- Normal load:
  - out_valid=in_valid, out_pc=in_pc, out_bd=in_bd, out_payload=in_payload.
  - DEC_TNEW=1: out_tnew = (in_tnew==0) ? 0 : in_tnew-1, saturating at 0 with no underflow.
  - DEC_TNEW=0: out_tnew = in_tnew.
- in_valid=0 on a normal load is treated as data: it is propagated as-is, and the payload is not zeroed.
- No internal FSM beyond the register and the counter; there is no combinational path from input to output.
- Reset or req asserted for several cycles holds the flushed values; the cycle after deassertion performs a normal load, or a stall/flush if those are asserted.

Decomposition:
- The shared package (macro header) holds PC_INIT, EXC_ENTRY and the payload field offsets (A2, A3, rd, RD2, ALUout, WhichtoReg, RegDst, DM_type, ExcCode, mfc0/mtc0/eret/syscall).
- Each stage-boundary wrapper uses those offsets to pack and unpack its payload.
- One natural sub-module: tnew_dec (saturating decrement, width TNEW_W), reused by the hazard unit.

Test Plan:
- reset=1 for 2 cycles, then in_pc=32'h3004, in_tnew=2, in_valid=1, in_payload=128'hA5 -> after reset: out_pc=32'h3000, out_tnew=0, out_valid=0; one cycle after release: out_pc=32'h3004, out_tnew=1, out_payload=128'hA5, out_valid=1.
- Tnew saturation: in_tnew=0, then 1, then 3 on successive loads -> out_tnew=0, 0, 2. With DEC_TNEW=0 and in_tnew=3 -> out_tnew=3.
- Stall: load pc=32'h3010, then stall=1 for 3 cycles while in_pc=32'h3014 and flush=1 -> out_pc stays 32'h3010, out_tnew does not decrement, bubble_cnt unchanged.
- Flush: in_pc=32'h3020, in_bd=1, in_payload=all-ones, flush=1 -> out_valid=0, out_payload=0, out_tnew=0, out_pc=32'h3020, out_bd=1, bubble_cnt +1.
- Exception with stall: req=1 and stall=1 together, in_pc=32'h3030 -> out_pc=32'h4180, out_valid=0, out_bd=0. Next cycle, with req=0 and no stall/flush, the input is loaded.
- Counter wrap: force bubble_cnt to 32'hFFFF_FFFF, then flush once -> bubble_cnt=0. Then reset=1 together with flush=1 -> bubble_cnt=0 and out_pc=32'h3000.
